// File: rtl/urv_pkg.sv
// Shared types for the uRV memory arbiter: FSM states, grant owner and lane width.
package urv_pkg;

    localparam int unsigned SEL_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_STORE,
        ST_RESP_I,
        ST_RESP_D
    } state_e;

    typedef enum logic {
        GRANT_FETCH,
        GRANT_DATA
    } grant_e;

    // Word-aligned mask keeping only the low `width` address bits.
    function automatic logic [31:0] addr_mask(input int unsigned width);
        logic [31:0] m;
        m = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return m & ~32'd3;
    endfunction

endpackage

// File: rtl/urv_mem_arbiter.sv
// Arbitrates instruction fetch and data load/store ports onto one
// single-port synchronous RAM, alternating grants on contention.
module urv_mem_arbiter
    import urv_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             im_req_i,
    input  logic [31:0]      im_addr_i,
    output logic [31:0]      im_data_o,
    output logic             im_valid_o,

    input  logic             dm_load_i,
    input  logic             dm_store_i,
    input  logic [31:0]      dm_addr_i,
    input  logic [31:0]      dm_data_s_i,
    input  logic [SEL_W-1:0] dm_data_select_i,
    output logic [31:0]      dm_data_l_o,
    output logic             dm_load_done_o,
    output logic             dm_store_done_o,
    output logic             dm_ready_o,

    output logic             mem_en_o,
    output logic [SEL_W-1:0] mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    input  logic [31:0]      mem_rdata_i
);

    localparam logic [31:0] ADDR_MASK = addr_mask(ADDR_WIDTH);

    state_e           state_q, state_d;
    grant_e           last_grant_q, last_grant_d;
    logic             mem_en_q, mem_en_d;
    logic [SEL_W-1:0] mem_we_q, mem_we_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [31:0]      im_data_q, im_data_d;
    logic [31:0]      dm_data_l_q, dm_data_l_d;
    logic             im_valid_q, im_valid_d;
    logic             load_done_q, load_done_d;
    logic             store_done_q, store_done_d;

    logic im_pend, ld_pend, st_pend, grant_data;

    // A port whose completion pulse is high this cycle is not pending yet.
    assign im_pend    = im_req_i   & ~im_valid_q;
    assign ld_pend    = dm_load_i  & ~load_done_q;
    assign st_pend    = dm_store_i & ~store_done_q;
    assign grant_data = (ld_pend | st_pend) & (~im_pend | (last_grant_q == GRANT_FETCH));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_en_d     = 1'b0;
        mem_we_d     = '0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        im_data_d    = im_data_q;
        dm_data_l_d  = dm_data_l_q;
        im_valid_d   = 1'b0;
        load_done_d  = 1'b0;
        store_done_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (grant_data) begin
                    last_grant_d = GRANT_DATA;
                    mem_addr_d   = dm_addr_i & ADDR_MASK;
                    if (st_pend) begin
                        state_d     = ST_STORE;
                        mem_en_d    = |dm_data_select_i;
                        mem_we_d    = dm_data_select_i;
                        mem_wdata_d = dm_data_s_i;
                    end else begin
                        state_d  = ST_LOAD;
                        mem_en_d = 1'b1;
                    end
                end else if (im_pend) begin
                    last_grant_d = GRANT_FETCH;
                    mem_addr_d   = im_addr_i & ADDR_MASK;
                    state_d      = ST_FETCH;
                    mem_en_d     = 1'b1;
                end
            end
            ST_FETCH: state_d = ST_RESP_I;
            ST_LOAD:  state_d = ST_RESP_D;
            ST_STORE: begin
                state_d      = ST_IDLE;
                store_done_d = 1'b1;
            end
            ST_RESP_I: begin
                state_d    = ST_IDLE;
                im_data_d  = mem_rdata_i;
                im_valid_d = 1'b1;
            end
            ST_RESP_D: begin
                state_d     = ST_IDLE;
                dm_data_l_d = mem_rdata_i;
                load_done_d = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_FETCH;
            mem_en_q     <= 1'b0;
            mem_we_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            im_data_q    <= '0;
            dm_data_l_q  <= '0;
            im_valid_q   <= 1'b0;
            load_done_q  <= 1'b0;
            store_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            im_data_q    <= im_data_d;
            dm_data_l_q  <= dm_data_l_d;
            im_valid_q   <= im_valid_d;
            load_done_q  <= load_done_d;
            store_done_q <= store_done_d;
        end
    end

    assign dm_ready_o      = (state_q == ST_IDLE);
    assign mem_en_o        = mem_en_q;
    assign mem_we_o        = mem_we_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign im_data_o       = im_data_q;
    assign im_valid_o      = im_valid_q;
    assign dm_data_l_o     = dm_data_l_q;
    assign dm_load_done_o  = load_done_q;
    assign dm_store_done_o = store_done_q;

endmodule

// File: tb/tb_urv_mem_arbiter.sv
// Directed bench for urv_mem_arbiter with a behavioural single-port synchronous RAM.
module tb_urv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        im_req, dm_load, dm_store;
    logic [31:0] im_addr, dm_addr, dm_data_s;
    logic [3:0]  dm_sel;
    logic [31:0] im_data, dm_data_l;
    logic        im_valid, ld_done, st_done, dm_ready;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic [31:0] ram [0:1023];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    urv_mem_arbiter #(.ADDR_WIDTH(12)) dut (
        .clk_i(clk), .rst_i(rst),
        .im_req_i(im_req), .im_addr_i(im_addr), .im_data_o(im_data), .im_valid_o(im_valid),
        .dm_load_i(dm_load), .dm_store_i(dm_store), .dm_addr_i(dm_addr),
        .dm_data_s_i(dm_data_s), .dm_data_select_i(dm_sel), .dm_data_l_o(dm_data_l),
        .dm_load_done_o(ld_done), .dm_store_done_o(st_done), .dm_ready_o(dm_ready),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we == 4'h0) mem_rdata <= ram[mem_addr[11:2]];
            else begin
                for (int b = 0; b < 4; b++)
                    if (mem_we[b]) ram[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int k;
        logic seen;
        k = 0;
        seen = 1'b0;
        dm_addr = a; dm_data_s = d; dm_sel = s; dm_store = 1'b1;
        while (k < 8 && !seen) begin
            tick();
            k++;
            if (st_done) seen = 1'b1;
        end
        dm_store = 1'b0;
        check("st_latency", 32'(k), 32'd2);
        tick();
        check("st_once", {31'd0, st_done}, 32'd0);
    endtask

    task automatic do_load(input logic [31:0] a, output logic [31:0] d);
        int k;
        logic seen;
        k = 0;
        seen = 1'b0;
        dm_addr = a; dm_load = 1'b1;
        while (k < 8 && !seen) begin
            tick();
            k++;
            if (ld_done) seen = 1'b1;
        end
        dm_load = 1'b0;
        d = dm_data_l;
        check("ld_latency", 32'(k), 32'd3);
        tick();
        check("ld_once", {31'd0, ld_done}, 32'd0);
    endtask

    logic [31:0] rd;

    initial begin
        rst = 1'b1;
        im_req = 0; dm_load = 0; dm_store = 0;
        im_addr = '0; dm_addr = '0; dm_data_s = '0; dm_sel = '0;
        tick(); tick();
        check("rst_ready", {31'd0, dm_ready}, 32'd1);
        check("rst_en", {31'd0, mem_en}, 32'd0);
        check("rst_we", {28'd0, mem_we}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_imdata", im_data, 32'd0);
        check("rst_dmdata", dm_data_l, 32'd0);
        check("rst_pulses", {29'd0, im_valid, ld_done, st_done}, 32'd0);
        rst = 1'b0;
        tick();

        // Fetch with exact latency
        do_store(32'h64, 32'h00000013, 4'hF);
        im_addr = 32'h64; im_req = 1'b1;
        tick();
        check("f_en", {31'd0, mem_en}, 32'd1);
        check("f_we", {28'd0, mem_we}, 32'd0);
        check("f_addr", mem_addr, 32'h064);
        check("f_ready", {31'd0, dm_ready}, 32'd0);
        check("f_valid1", {31'd0, im_valid}, 32'd0);
        tick();
        check("f_en2", {31'd0, mem_en}, 32'd0);
        check("f_valid2", {31'd0, im_valid}, 32'd0);
        tick();
        check("f_valid3", {31'd0, im_valid}, 32'd1);
        check("f_data", im_data, 32'h00000013);
        check("f_ready3", {31'd0, dm_ready}, 32'd1);
        im_req = 1'b0;
        tick();
        check("f_valid4", {31'd0, im_valid}, 32'd0);
        check("f_hold", im_data, 32'h00000013);

        // Full-word store then load back
        dm_addr = 32'h100; dm_data_s = 32'hDEADBEEF; dm_sel = 4'hF; dm_store = 1'b1;
        tick();
        check("s_en", {31'd0, mem_en}, 32'd1);
        check("s_we", {28'd0, mem_we}, 32'hF);
        check("s_wdata", mem_wdata, 32'hDEADBEEF);
        check("s_addr", mem_addr, 32'h100);
        check("s_done1", {31'd0, st_done}, 32'd0);
        tick();
        check("s_done2", {31'd0, st_done}, 32'd1);
        check("s_en2", {31'd0, mem_en}, 32'd0);
        dm_store = 1'b0;
        tick();
        check("s_done3", {31'd0, st_done}, 32'd0);
        do_load(32'h100, rd);
        check("ld_deadbeef", rd, 32'hDEADBEEF);

        // Byte-lane store
        do_store(32'h200, 32'h55667788, 4'hF);
        do_store(32'h200, 32'h000000AA, 4'h1);
        do_load(32'h200, rd);
        check("byte_merge", rd, 32'h556677AA);

        // Store and load together: store first, load follows
        dm_addr = 32'h100; dm_data_s = 32'h12345678; dm_sel = 4'hF;
        dm_store = 1'b1; dm_load = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check($sformatf("sl_k%0d", k), {30'd0, st_done, ld_done},
                  (k == 2) ? 32'd2 : (k == 5) ? 32'd1 : 32'd0);
            if (k == 2) dm_store = 1'b0;
        end
        check("sl_data", dm_data_l, 32'h12345678);
        dm_load = 1'b0;
        tick();

        // Address masking and zero-lane store
        dm_addr = 32'hFFFF1004; dm_data_s = 32'hCAFEF00D; dm_sel = 4'h0; dm_store = 1'b1;
        tick();
        check("m_addr", mem_addr, 32'h004);
        check("m_en", {31'd0, mem_en}, 32'd0);
        check("m_we", {28'd0, mem_we}, 32'd0);
        tick();
        check("m_done", {31'd0, st_done}, 32'd1);
        dm_store = 1'b0;
        tick();
        dm_addr = 32'hFFFF1007; dm_load = 1'b1;
        tick();
        check("m_ld_addr", mem_addr, 32'h004);
        check("m_ld_en", {31'd0, mem_en}, 32'd1);
        tick(); tick();
        check("m_ld_done", {31'd0, ld_done}, 32'd1);
        dm_load = 1'b0;
        tick();

        // Contention from reset: data, fetch, data, fetch
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        im_addr = 32'h64; dm_addr = 32'h100; im_req = 1'b1; dm_load = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            check($sformatf("arb_k%0d", k), {30'd0, ld_done, im_valid},
                  (k == 3 || k == 9) ? 32'd2 : (k == 6 || k == 12) ? 32'd1 : 32'd0);
        end
        check("arb_imdata", im_data, 32'h00000013);
        check("arb_dmdata", dm_data_l, 32'h12345678);
        im_req = 1'b0; dm_load = 1'b0;
        tick();

        // Reset while in LOAD
        dm_addr = 32'h100; dm_load = 1'b1;
        tick();
        check("r_en", {31'd0, mem_en}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("r_ready", {31'd0, dm_ready}, 32'd1);
        check("r_en0", {31'd0, mem_en}, 32'd0);
        check("r_dmdata", dm_data_l, 32'd0);
        dm_load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("r_nodone", {31'd0, ld_done}, 32'd0);
        end
        rst = 1'b0;
        tick();
        check("r_nodone2", {31'd0, ld_done}, 32'd0);
        do_load(32'h100, rd);
        check("r_reload", rd, 32'h12345678);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/urv_mem_arbiter.md
URV_MEM_ARBITER -- requirements
Module: urv_mem_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, byte-address bits passed to memory; upper bits discarded.
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-high.
REQ-004 im_req_i  in  1  fetch request, level, held by CPU until im_valid_o.
REQ-005 im_addr_i  in  32  fetch byte address.
REQ-006 im_data_o  out  32  fetched word, held until next fetch completes.
REQ-007 im_valid_o  out  1  one-cycle pulse, im_data_o valid.
REQ-008 dm_load_i / dm_store_i  in  1 each  data load / store request, level, held until matching done.
REQ-009 dm_addr_i  in  32; dm_data_s_i  in  32; dm_data_select_i  in  4  byte lanes, bit3 = [31:24].
REQ-010 dm_data_l_o  out  32  loaded word, held until next load completes.
REQ-011 dm_load_done_o / dm_store_done_o  out  1 each  one-cycle completion pulses.
REQ-012 dm_ready_o  out  1  high only while FSM is IDLE.
REQ-013 mem_en_o  out  1; mem_we_o  out  4; mem_addr_o  out  32; mem_wdata_o  out  32  single-port synchronous RAM side.
REQ-014 mem_rdata_i  in  32  read data, valid the cycle after mem_en_o=1 with mem_we_o=0.

Function
REQ-015 FSM states: IDLE, FETCH, LOAD, STORE, RESP_I, RESP_D.
REQ-016 IDLE -> FETCH / LOAD / STORE per arbitration of pending requests; no request -> stay IDLE.
REQ-017 Arbitration: single pending port granted; both pending -> port not granted last time wins; last_grant resets to fetch, so data wins first tie.
REQ-018 dm_store_i and dm_load_i both high -> store served; load stays pending.
REQ-019 A port's request is ignored in the cycle its own done/valid pulse is high (no double service).
REQ-020 FETCH/LOAD: mem_en_o=1, mem_we_o=0, address latched at grant; next state RESP_I / RESP_D.
REQ-021 RESP_I: edge latches mem_rdata_i into im_data_o, pulses im_valid_o next cycle, returns IDLE; RESP_D identical for dm_data_l_o / dm_load_done_o.
REQ-022 STORE: mem_en_o=1, mem_we_o=latched select, mem_wdata_o=latched data for one cycle; dm_store_done_o pulses next cycle; returns IDLE.
REQ-023 dm_data_select_i=0 store: no write (mem_we_o=0, mem_en_o=0), done still pulses.
REQ-024 mem_addr_o = latched address masked to ADDR_WIDTH bits with [1:0] forced 0; bits above ADDR_WIDTH are 0.
REQ-025 Latency: read request seen at edge N -> valid/done high cycle after edge N+2; store -> done after edge N+1.
REQ-026 Outside FETCH/LOAD/STORE, mem_en_o=0 and mem_we_o=0.
REQ-027 Request dropped mid-transaction: transaction completes, pulse still issued.

Reset
REQ-028 rst_i high: state IDLE, last_grant=fetch, all outputs 0 except dm_ready_o=1, im_data_o/dm_data_l_o=0.
REQ-029 Reset mid-transaction aborts without issuing done/valid pulse; no memory write after rst_i asserts.

Structure
REQ-030 Shared package urv_pkg holds FSM state enum, grant enum, lane-select width constant.
REQ-031 Single module, no sub-modules; arbitration inline.

Verification
REQ-032 Fetch only, im_addr_i=0x64, RAM word 0x00000013 -> mem_addr_o=0x064, im_data_o=0x00000013, im_valid_o 3 cycles after request.
REQ-033 Store 0xDEADBEEF, select 0xF, addr 0x100, then load 0x100 -> dm_data_l_o=0xDEADBEEF, one done pulse each.
REQ-034 Byte store select 0x1 data 0x000000AA to word 0x55667788 -> reads back 0x556677AA.
REQ-035 im_req_i and dm_load_i rise same cycle, held continuously -> grants alternate data, fetch, data; neither port starves.
REQ-036 dm_addr_i=0xFFFF1004, ADDR_WIDTH=12 -> mem_addr_o=0x004; select 0 store -> no mem_we_o, done pulses.
REQ-037 rst_i asserted in LOAD state -> no dm_load_done_o, outputs at reset values, next request served normally.
